// File: rtl/axi_host_arbiter.sv
// axi_host_arbiter: round-robin N-to-1 AXI arbiter, one transaction in flight downstream
module axi_host_arbiter #(
  parameter int NumHosts  = 2,
  parameter int IdWidth   = 1,
  parameter int AddrWidth = 56,
  parameter int DataWidth = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumHosts-1:0]             host_aw_valid,
  output logic [NumHosts-1:0]             host_aw_ready,
  input  logic [NumHosts*IdWidth-1:0]     host_aw_id,
  input  logic [NumHosts*AddrWidth-1:0]   host_aw_addr,
  input  logic [NumHosts*8-1:0]           host_aw_len,
  input  logic [NumHosts*3-1:0]           host_aw_size,
  input  logic [NumHosts-1:0]             host_ar_valid,
  output logic [NumHosts-1:0]             host_ar_ready,
  input  logic [NumHosts*IdWidth-1:0]     host_ar_id,
  input  logic [NumHosts*AddrWidth-1:0]   host_ar_addr,
  input  logic [NumHosts*8-1:0]           host_ar_len,
  input  logic [NumHosts*3-1:0]           host_ar_size,
  input  logic [NumHosts-1:0]             host_w_valid,
  output logic [NumHosts-1:0]             host_w_ready,
  input  logic [NumHosts*DataWidth-1:0]   host_w_data,
  input  logic [NumHosts*DataWidth/8-1:0] host_w_strb,
  input  logic [NumHosts-1:0]             host_w_last,
  output logic [NumHosts-1:0]             host_r_valid,
  input  logic [NumHosts-1:0]             host_r_ready,
  output logic [IdWidth-1:0]              host_r_id,
  output logic [DataWidth-1:0]            host_r_data,
  output logic [1:0]                      host_r_resp,
  output logic                            host_r_last,
  output logic [NumHosts-1:0]             host_b_valid,
  input  logic [NumHosts-1:0]             host_b_ready,
  output logic [IdWidth-1:0]              host_b_id,
  output logic [1:0]                      host_b_resp,
  output logic                            dev_aw_valid,
  input  logic                            dev_aw_ready,
  output logic [IdWidth-1:0]              dev_aw_id,
  output logic [AddrWidth-1:0]            dev_aw_addr,
  output logic [7:0]                      dev_aw_len,
  output logic [2:0]                      dev_aw_size,
  output logic                            dev_ar_valid,
  input  logic                            dev_ar_ready,
  output logic [IdWidth-1:0]              dev_ar_id,
  output logic [AddrWidth-1:0]            dev_ar_addr,
  output logic [7:0]                      dev_ar_len,
  output logic [2:0]                      dev_ar_size,
  output logic                            dev_w_valid,
  input  logic                            dev_w_ready,
  output logic [DataWidth-1:0]            dev_w_data,
  output logic [DataWidth/8-1:0]          dev_w_strb,
  output logic                            dev_w_last,
  input  logic                            dev_r_valid,
  output logic                            dev_r_ready,
  input  logic [IdWidth-1:0]              dev_r_id,
  input  logic [DataWidth-1:0]            dev_r_data,
  input  logic [1:0]                      dev_r_resp,
  input  logic                            dev_r_last,
  input  logic                            dev_b_valid,
  output logic                            dev_b_ready,
  input  logic [IdWidth-1:0]              dev_b_id,
  input  logic [1:0]                      dev_b_resp
);
  localparam int Slots = 2 * NumHosts;
  localparam int PW    = $clog2(Slots);
  localparam int OW    = $clog2(NumHosts);
  localparam int SW    = DataWidth / 8;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRESP, RDATA} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       rr_q, rr_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic                rd_q, rd_d;
  logic [Slots-1:0]    slot_valid;
  logic [NumHosts-1:0] sel;
  logic                found;
  logic [PW-1:0]       win;
  logic                in_aw, in_ar;

  assign sel   = NumHosts'(1) << owner_q;
  assign in_aw = (state_q == ADDR) && !rd_q;
  assign in_ar = (state_q == ADDR) && rd_q;

  assign dev_aw_valid  = in_aw && host_aw_valid[owner_q];
  assign dev_aw_id     = host_aw_id[owner_q*IdWidth +: IdWidth];
  assign dev_aw_addr   = host_aw_addr[owner_q*AddrWidth +: AddrWidth];
  assign dev_aw_len    = host_aw_len[owner_q*8 +: 8];
  assign dev_aw_size   = host_aw_size[owner_q*3 +: 3];
  assign host_aw_ready = (in_aw && dev_aw_ready) ? sel : '0;

  assign dev_ar_valid  = in_ar && host_ar_valid[owner_q];
  assign dev_ar_id     = host_ar_id[owner_q*IdWidth +: IdWidth];
  assign dev_ar_addr   = host_ar_addr[owner_q*AddrWidth +: AddrWidth];
  assign dev_ar_len    = host_ar_len[owner_q*8 +: 8];
  assign dev_ar_size   = host_ar_size[owner_q*3 +: 3];
  assign host_ar_ready = (in_ar && dev_ar_ready) ? sel : '0;

  // W only opens after the owner's AW has completed downstream
  assign dev_w_valid  = (state_q == WDATA) && host_w_valid[owner_q];
  assign dev_w_data   = host_w_data[owner_q*DataWidth +: DataWidth];
  assign dev_w_strb   = host_w_strb[owner_q*SW +: SW];
  assign dev_w_last   = host_w_last[owner_q];
  assign host_w_ready = ((state_q == WDATA) && dev_w_ready) ? sel : '0;

  assign host_r_valid = ((state_q == RDATA) && dev_r_valid) ? sel : '0;
  assign dev_r_ready  = (state_q == RDATA) && host_r_ready[owner_q];
  assign host_r_id    = dev_r_id;
  assign host_r_data  = dev_r_data;
  assign host_r_resp  = dev_r_resp;
  assign host_r_last  = dev_r_last;

  assign host_b_valid = ((state_q == WRESP) && dev_b_valid) ? sel : '0;
  assign dev_b_ready  = (state_q == WRESP) && host_b_ready[owner_q];
  assign host_b_id    = dev_b_id;
  assign host_b_resp  = dev_b_resp;

  always_comb begin
    for (int h = 0; h < NumHosts; h++) begin
      slot_valid[2*h]   = host_aw_valid[h];
      slot_valid[2*h+1] = host_ar_valid[h];
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < Slots; k++) begin
      if (!found && slot_valid[PW'((int'(rr_q) + k) % Slots)]) begin
        found = 1'b1;
        win   = PW'((int'(rr_q) + k) % Slots);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: if (found) begin
        state_d = ADDR;
        owner_d = OW'(win >> 1);
        rd_d    = win[0];
        rr_d    = (win == PW'(Slots - 1)) ? '0 : win + 1'b1;
      end
      ADDR:    if (rd_q ? (dev_ar_valid && dev_ar_ready) : (dev_aw_valid && dev_aw_ready))
                 state_d = rd_q ? RDATA : WDATA;
      WDATA:   if (dev_w_valid && dev_w_ready && dev_w_last) state_d = WRESP;
      WRESP:   if (dev_b_valid && dev_b_ready) state_d = IDLE;
      RDATA:   if (dev_r_valid && dev_r_ready && dev_r_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      rd_q    <= rd_d;
    end
  end
endmodule

// File: tb/tb_axi_host_arbiter.sv
// tb_axi_host_arbiter: directed vector table plus hand-written corner sequences
module tb_axi_host_arbiter;
  logic         clk_i = 1'b0, rst_i = 1'b1;
  logic [1:0]   host_aw_valid, host_aw_ready, host_ar_valid, host_ar_ready;
  logic [1:0]   host_aw_id, host_ar_id;
  logic [111:0] host_aw_addr, host_ar_addr;
  logic [15:0]  host_aw_len, host_ar_len;
  logic [5:0]   host_aw_size, host_ar_size;
  logic [1:0]   host_w_valid, host_w_ready, host_w_last;
  logic [127:0] host_w_data;
  logic [15:0]  host_w_strb;
  logic [1:0]   host_r_valid, host_r_ready, host_b_valid, host_b_ready;
  logic         host_r_id, host_r_last, host_b_id;
  logic [63:0]  host_r_data;
  logic [1:0]   host_r_resp, host_b_resp;
  logic         dev_aw_valid, dev_aw_ready, dev_aw_id, dev_ar_valid, dev_ar_ready, dev_ar_id;
  logic [55:0]  dev_aw_addr, dev_ar_addr;
  logic [7:0]   dev_aw_len, dev_ar_len;
  logic [2:0]   dev_aw_size, dev_ar_size;
  logic         dev_w_valid, dev_w_ready, dev_w_last;
  logic [63:0]  dev_w_data, dev_r_data;
  logic [7:0]   dev_w_strb;
  logic         dev_r_valid, dev_r_ready, dev_r_id, dev_r_last;
  logic [1:0]   dev_r_resp, dev_b_resp;
  logic         dev_b_valid, dev_b_ready, dev_b_id;
  logic [14:0]  all_vr;
  int           npass = 0, nchk = 0;

  typedef struct {
    logic [1:0] aw;
    logic [1:0] ar;
    int         slot;
  } vec_t;
  vec_t tbl[10];

  axi_host_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_aw_valid(host_aw_valid), .host_aw_ready(host_aw_ready), .host_aw_id(host_aw_id),
    .host_aw_addr(host_aw_addr), .host_aw_len(host_aw_len), .host_aw_size(host_aw_size),
    .host_ar_valid(host_ar_valid), .host_ar_ready(host_ar_ready), .host_ar_id(host_ar_id),
    .host_ar_addr(host_ar_addr), .host_ar_len(host_ar_len), .host_ar_size(host_ar_size),
    .host_w_valid(host_w_valid), .host_w_ready(host_w_ready), .host_w_data(host_w_data),
    .host_w_strb(host_w_strb), .host_w_last(host_w_last),
    .host_r_valid(host_r_valid), .host_r_ready(host_r_ready), .host_r_id(host_r_id),
    .host_r_data(host_r_data), .host_r_resp(host_r_resp), .host_r_last(host_r_last),
    .host_b_valid(host_b_valid), .host_b_ready(host_b_ready), .host_b_id(host_b_id),
    .host_b_resp(host_b_resp),
    .dev_aw_valid(dev_aw_valid), .dev_aw_ready(dev_aw_ready), .dev_aw_id(dev_aw_id),
    .dev_aw_addr(dev_aw_addr), .dev_aw_len(dev_aw_len), .dev_aw_size(dev_aw_size),
    .dev_ar_valid(dev_ar_valid), .dev_ar_ready(dev_ar_ready), .dev_ar_id(dev_ar_id),
    .dev_ar_addr(dev_ar_addr), .dev_ar_len(dev_ar_len), .dev_ar_size(dev_ar_size),
    .dev_w_valid(dev_w_valid), .dev_w_ready(dev_w_ready), .dev_w_data(dev_w_data),
    .dev_w_strb(dev_w_strb), .dev_w_last(dev_w_last),
    .dev_r_valid(dev_r_valid), .dev_r_ready(dev_r_ready), .dev_r_id(dev_r_id),
    .dev_r_data(dev_r_data), .dev_r_resp(dev_r_resp), .dev_r_last(dev_r_last),
    .dev_b_valid(dev_b_valid), .dev_b_ready(dev_b_ready), .dev_b_id(dev_b_id),
    .dev_b_resp(dev_b_resp)
  );

  assign all_vr = {host_aw_ready, host_ar_ready, host_w_ready, host_r_valid, host_b_valid,
                   dev_aw_valid, dev_ar_valid, dev_w_valid, dev_r_ready, dev_b_ready};

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clear_inputs();
    host_aw_valid = '0; host_ar_valid = '0; host_w_valid = '0; host_w_last = '0;
    host_r_ready = '0; host_b_ready = '0;
    dev_aw_ready = 0; dev_ar_ready = 0; dev_w_ready = 0;
    dev_r_valid = 0; dev_r_last = 0; dev_b_valid = 0;
  endtask

  task automatic do_reset();
    rst_i = 1;
    clear_inputs();
    tick();
    tick();
    #1;
    chk("reset_outputs_zero", all_vr, 0);
    rst_i = 0;
  endtask

  // Waits for the next downstream address valid and decodes which slot won from the address.
  task automatic wait_grant(output int slot, output int cyc);
    slot = -1;
    cyc  = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (dev_aw_valid || dev_ar_valid) begin
        chk("single_dev_addr_valid", {63'd0, dev_aw_valid & dev_ar_valid}, 0);
        if (dev_aw_valid) slot = (dev_aw_addr == 56'h2000) ? 0 : (dev_aw_addr == 56'h3000) ? 2 : 98;
        else slot = (dev_ar_addr == 56'h1000) ? 1 : (dev_ar_addr == 56'h1100) ? 3 : 99;
        break;
      end
      tick();
      cyc++;
    end
    if (slot < 0) chk("grant_timeout", 1, 0);
  endtask

  task automatic do_txn(input int slot);
    int h;
    logic [1:0] oh;
    h  = slot / 2;
    oh = 2'b01 << h;
    if (slot % 2 == 1) begin
      dev_ar_ready = 1; #1;
      chk("ar_ready_owner", host_ar_ready, oh);
      tick();
      dev_ar_ready = 0; host_ar_valid[h] = 0;
      dev_r_valid = 1; dev_r_last = 1; dev_r_data = 64'hD00D + 64'(slot); host_r_ready[h] = 1; #1;
      chk("r_valid_owner", host_r_valid, oh);
      chk("r_data", host_r_data, 64'hD00D + 64'(slot));
      tick();
      dev_r_valid = 0; dev_r_last = 0; host_r_ready = '0;
    end else begin
      dev_aw_ready = 1; #1;
      chk("aw_ready_owner", host_aw_ready, oh);
      tick();
      dev_aw_ready = 0; host_aw_valid[h] = 0;
      host_w_valid[h] = 1; host_w_last[h] = 1; host_w_data[h*64 +: 64] = 64'hBEEF0 + 64'(slot);
      dev_w_ready = 1; #1;
      chk("w_valid", {63'd0, dev_w_valid}, 1);
      chk("w_data", dev_w_data, 64'hBEEF0 + 64'(slot));
      chk("w_ready_owner", host_w_ready, oh);
      tick();
      host_w_valid = '0; host_w_last = '0; dev_w_ready = 0;
      dev_b_valid = 1; host_b_ready[h] = 1; #1;
      chk("b_valid_owner", host_b_valid, oh);
      chk("b_ready_dev", {63'd0, dev_b_ready}, 1);
      tick();
      dev_b_valid = 0; host_b_ready = '0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int slot, cyc;
    int exp_order[3];
    tbl[0] = '{2'b11, 2'b11, 0};
    tbl[1] = '{2'b11, 2'b11, 1};
    tbl[2] = '{2'b11, 2'b11, 2};
    tbl[3] = '{2'b11, 2'b11, 3};
    tbl[4] = '{2'b00, 2'b10, 3};
    tbl[5] = '{2'b10, 2'b00, 2};
    tbl[6] = '{2'b01, 2'b00, 0};
    tbl[7] = '{2'b11, 2'b00, 2};
    tbl[8] = '{2'b00, 2'b01, 1};
    tbl[9] = '{2'b01, 2'b10, 3};
    host_aw_id = 2'b10; host_ar_id = 2'b10;
    host_aw_addr = {56'h3000, 56'h2000}; host_ar_addr = {56'h1100, 56'h1000};
    host_aw_len = '0; host_ar_len = {8'd0, 8'd3};
    host_aw_size = {3'd3, 3'd3}; host_ar_size = {3'd3, 3'd3};
    host_w_data = '0; host_w_strb = '1;
    dev_r_id = 0; dev_r_data = '0; dev_r_resp = 2'b00; dev_b_id = 0; dev_b_resp = 2'b00;
    clear_inputs();

    // host0 read burst of 4
    do_reset();
    host_ar_valid[0] = 1; #1;
    chk("r031_idle_no_ar", {63'd0, dev_ar_valid}, 0);
    tick(); #1;
    chk("r031_ar_valid_n1", {63'd0, dev_ar_valid}, 1);
    chk("r031_ar_addr", {8'd0, dev_ar_addr}, 64'h1000);
    chk("r031_ar_len", {56'd0, dev_ar_len}, 3);
    chk("r031_ar_ready_wait", host_ar_ready, 0);
    dev_ar_ready = 1; #1;
    chk("r031_ar_ready", host_ar_ready, 2'b01);
    tick();
    dev_ar_ready = 0; host_ar_valid = '0;
    for (int b = 0; b < 4; b++) begin
      dev_r_valid = 1; dev_r_last = (b == 3); dev_r_data = 64'hA0 + 64'(b); host_r_ready = 2'b11; #1;
      chk("r031_r_valid_h0", host_r_valid, 2'b01);
      chk("r031_r_last", {63'd0, host_r_last}, {63'd0, b == 3});
      chk("r031_r_data", host_r_data, 64'hA0 + 64'(b));
      tick();
    end
    dev_r_last = 0; #1;
    chk("r031_idle_after_r_valid", host_r_valid, 0);
    chk("r031_idle_after_r_ready", {63'd0, dev_r_ready}, 0);
    clear_inputs();

    // arbitration table; the reset also proves rr restarts at slot 0
    do_reset();
    foreach (tbl[i]) begin
      host_aw_valid = tbl[i].aw; host_ar_valid = tbl[i].ar; #1;
      chk("tbl_idle_no_dev_valid", {62'd0, dev_aw_valid, dev_ar_valid}, 0);
      wait_grant(slot, cyc);
      chk($sformatf("tbl%0d_slot", i), 64'(slot), 64'(tbl[i].slot));
      chk($sformatf("tbl%0d_latency", i), 64'(cyc), 1);
      do_txn(slot);
      host_aw_valid = '0; host_ar_valid = '0;
    end

    // grant order from reset with three requests pending
    do_reset();
    host_aw_valid = 2'b11; host_ar_valid = 2'b01;
    exp_order = '{0, 1, 2};
    foreach (exp_order[i]) begin
      wait_grant(slot, cyc);
      chk($sformatf("r032_grant%0d", i), 64'(slot), 64'(exp_order[i]));
      do_txn(slot);
    end

    // B backpressure holds WResp and blocks new grants
    do_reset();
    host_aw_len[7:0] = 8'd1;
    host_aw_valid[0] = 1;
    wait_grant(slot, cyc);
    chk("r033_slot", 64'(slot), 0);
    chk("r033_aw_len", {56'd0, dev_aw_len}, 1);
    dev_aw_ready = 1;
    tick();
    dev_aw_ready = 0; host_aw_valid = '0;
    host_w_valid[0] = 1; host_w_last[0] = 0; dev_w_ready = 1;
    tick();
    host_w_last[0] = 1;
    tick();
    host_w_valid = '0; host_w_last = '0; dev_w_ready = 0;
    dev_b_valid = 1; host_ar_valid[1] = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("r033_b_valid_hold", host_b_valid, 2'b01);
      chk("r033_b_ready_low", {63'd0, dev_b_ready}, 0);
      chk("r033_no_new_grant", {63'd0, dev_ar_valid}, 0);
      tick();
    end
    host_b_ready[0] = 1; #1;
    chk("r033_b_ready", {63'd0, dev_b_ready}, 1);
    tick();
    host_b_ready = '0; #1;
    chk("r033_b_once", host_b_valid, 0);
    dev_b_valid = 0;
    wait_grant(slot, cyc);
    chk("r033_next_grant", 64'(slot), 3);
    do_txn(slot);
    host_aw_len = '0;

    // early W from host1 is held off until its AW completes
    do_reset();
    host_w_valid[1] = 1; host_w_last[1] = 1; host_w_data[127:64] = 64'h55AA; dev_w_ready = 1;
    host_aw_valid[1] = 1; #1;
    chk("r034_idle_w_ready", host_w_ready, 0);
    chk("r034_idle_dev_w", {63'd0, dev_w_valid}, 0);
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      chk("r034_addr_aw_valid", {63'd0, dev_aw_valid}, 1);
      chk("r034_addr_w_ready", host_w_ready, 0);
      chk("r034_addr_dev_w", {63'd0, dev_w_valid}, 0);
    end
    dev_aw_ready = 1;
    tick();
    dev_aw_ready = 0; host_aw_valid = '0; #1;
    chk("r034_wdata_w_ready", host_w_ready, 2'b10);
    chk("r034_wdata_dev_w", {63'd0, dev_w_valid}, 1);
    chk("r034_wdata_data", dev_w_data, 64'h55AA);
    tick();
    host_w_valid = '0; host_w_last = '0; dev_w_ready = 0;
    dev_b_valid = 1; host_b_ready[1] = 1; #1;
    chk("r034_b_valid_h1", host_b_valid, 2'b10);
    tick();
    clear_inputs();

    // reset during read beat 2 drops the burst; pending host1 AR wins afterwards
    do_reset();
    host_ar_valid[0] = 1;
    wait_grant(slot, cyc);
    chk("r035_first_slot", 64'(slot), 1);
    dev_ar_ready = 1;
    tick();
    dev_ar_ready = 0; host_ar_valid = '0;
    dev_r_valid = 1; dev_r_last = 0; host_r_ready[0] = 1;
    tick();
    host_ar_valid[1] = 1; #1;
    chk("r035_beat2_valid", host_r_valid, 2'b01);
    rst_i = 1; #1;
    chk("r035_async_outputs_zero", all_vr, 0);
    dev_r_valid = 0; host_r_ready = '0;
    tick();
    tick();
    rst_i = 0;
    wait_grant(slot, cyc);
    chk("r035_after_reset_slot", 64'(slot), 3);
    chk("r035_after_reset_latency", 64'(cyc), 1);
    do_txn(slot);

    // rr pointer wrap from slot 3 to slot 0
    do_reset();
    host_aw_valid[1] = 1;
    wait_grant(slot, cyc);
    chk("r036_setup_slot", 64'(slot), 2);
    do_txn(slot);
    host_aw_valid[0] = 1; host_ar_valid[1] = 1;
    wait_grant(slot, cyc);
    chk("r036_wrap_first", 64'(slot), 3);
    do_txn(slot);
    wait_grant(slot, cyc);
    chk("r036_wrap_second", 64'(slot), 0);
    chk("r036_wrap_latency", 64'(cyc), 1);
    do_txn(slot);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
